// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: geometry defaults, sequencer states and maintenance modes.
package cache_pkg;

  localparam int unsigned DEF_IDX_BITS = 13;
  localparam int unsigned DEF_WAYS     = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CHK,
    WB,
    UPD,
    DONE
  } seq_state_t;

  // Mode bits are {flush, inval}, matching the start pulses.
  typedef logic [1:0] mode_t;
  localparam mode_t M_NONE        = 2'b00;
  localparam mode_t M_INVAL       = 2'b01;
  localparam mode_t M_FLUSH       = 2'b10;
  localparam mode_t M_FLUSH_INVAL = 2'b11;

endpackage

// File: rtl/first_set4.sv
// Lowest-set-bit picker for a 4-way mask.
module first_set4 (
  input  logic [3:0] mask,
  output logic [1:0] way,
  output logic       any
);

  always_comb begin
    way = 2'd0;
    any = |mask;
    if (mask[0])      way = 2'd0;
    else if (mask[1]) way = 2'd1;
    else if (mask[2]) way = 2'd2;
    else if (mask[3]) way = 2'd3;
  end

endmodule

// File: rtl/cache_flush_seq.sv
// Whole-cache flush/invalidate walker: reads each set's valid/dirty bits,
// writes back dirty lines one way at a time, then clears the bits.
module cache_flush_seq
  import cache_pkg::*;
#(
  parameter int unsigned IDX_BITS = DEF_IDX_BITS,
  parameter int unsigned WAYS     = DEF_WAYS,
  parameter int unsigned CNT_BITS = IDX_BITS + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_flush,
  input  logic                start_inval,
  output logic                busy,
  output logic                done,
  output logic                arr_rd_en,
  output logic [IDX_BITS-1:0] arr_idx,
  input  logic [WAYS-1:0]     val_bits,
  input  logic [WAYS-1:0]     mod_bits,
  output logic                wb_req,
  output logic [1:0]          wb_way,
  output logic [IDX_BITS-1:0] wb_idx,
  input  logic                wb_ack,
  output logic                bit_wr_en,
  output logic [WAYS-1:0]     clr_val_mask,
  output logic [WAYS-1:0]     clr_mod_mask,
  output logic [CNT_BITS-1:0] wb_count
);

  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [WAYS-1:0]     ALL_WAYS = '1;

  seq_state_t          state_q, state_n;
  logic [IDX_BITS-1:0] idx_q, idx_n;
  mode_t               mode_q, mode_n;
  logic [WAYS-1:0]     pend_q, pend_n;
  logic [WAYS-1:0]     done_mask_q, done_mask_n;
  logic [CNT_BITS-1:0] wb_count_n;
  logic [WAYS-1:0]     way_oh;
  logic [1:0]          nxt_way;
  logic                nxt_any;
  logic                start_any;

  assign start_any = start_flush | start_inval;

  // Pending/completed way masks and writeback counter.
  always_comb begin
    pend_n      = pend_q;
    done_mask_n = done_mask_q;
    wb_count_n  = wb_count;
    way_oh      = WAYS'(1) << wb_way;
    case (state_q)
      IDLE: if (start_any) wb_count_n = '0;
      CHK:  pend_n = mode_q[1] ? (val_bits & mod_bits) : '0;
      WB: begin
        if (wb_ack) begin
          pend_n      = pend_q & ~way_oh;
          done_mask_n = done_mask_q | way_oh;
          if (wb_count != CNT_MAX) wb_count_n = wb_count + CNT_BITS'(1);
        end
      end
      UPD: begin
        pend_n      = '0;
        done_mask_n = '0;
      end
      default: ;
    endcase
  end

  first_set4 u_pick (
    .mask (pend_n),
    .way  (nxt_way),
    .any  (nxt_any)
  );

  // Next-state and walk index.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    mode_n  = mode_q;
    case (state_q)
      IDLE: begin
        if (start_any) begin
          state_n = RD;
          idx_n   = '0;
          mode_n  = {start_flush, start_inval};
        end
      end
      RD:  state_n = CHK;
      CHK: state_n = nxt_any ? WB : UPD;
      WB:  if (!nxt_any) state_n = UPD;
      UPD: begin
        if (idx_q == IDX_LAST) begin
          state_n = DONE;
        end else begin
          idx_n   = idx_q + IDX_BITS'(1);
          state_n = RD;
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mode_q      <= M_NONE;
      pend_q      <= '0;
      done_mask_q <= '0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      mode_q      <= mode_n;
      pend_q      <= pend_n;
      done_mask_q <= done_mask_n;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      arr_rd_en    <= 1'b0;
      arr_idx      <= '0;
      wb_req       <= 1'b0;
      wb_way       <= 2'd0;
      wb_idx       <= '0;
      bit_wr_en    <= 1'b0;
      clr_val_mask <= '0;
      clr_mod_mask <= '0;
      wb_count     <= '0;
    end else begin
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
      arr_rd_en    <= (state_n == RD);
      arr_idx      <= idx_n;
      wb_req       <= (state_n == WB);
      wb_way       <= (state_n == WB) ? nxt_way : 2'd0;
      wb_idx       <= idx_n;
      bit_wr_en    <= (state_n == UPD);
      clr_val_mask <= ((state_n == UPD) && (mode_n != M_FLUSH)) ? ALL_WAYS : '0;
      clr_mod_mask <= (state_n != UPD)  ? '0 :
                      (mode_n == M_FLUSH) ? done_mask_n : ALL_WAYS;
      wb_count     <= wb_count_n;
    end
  end

endmodule
